// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and helpers for the SPI frame writer
package spi_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, END, GAP} state_e;

  // SCL edges per byte: 8 leading plus 8 trailing.
  localparam int EDGES_PER_BYTE = 16;

  function automatic int nbytes(input int width);
    return (width + 7) / 8;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int div_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// rtl/spi_tick_gen.sv - SCL half-period divider with synchronous clear
module spi_tick_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = div_w(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == LAST);

  // Count 0..CLK_DIV-1; a clear restarts the half-period so the first tick lands CLK_DIV cycles later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/spi_frame_writer.sv
// rtl/spi_frame_writer.sv - SPI parent transmitter for one sample per frame (SPI_LSB_FIRST_EN selects LSB-first)
module spi_frame_writer
  import spi_pkg::*;
#(
  parameter int   DATA_W   = 12,
  parameter int   CLK_DIV  = 250,
  parameter logic CPOL     = 1'b0,
  parameter logic CPHA     = 1'b1,
  parameter int   GAP_HALF = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] sample,
  output logic              busy,
  output logic              done,
  output logic              SCL,
  output logic              SS,
  output logic              MOSI,
  output logic [2:0]        byte_idx
);

  localparam int NB = nbytes(DATA_W);
  localparam int SW = NB * 8;
  localparam int GW = div_w(GAP_HALF + 1);
  localparam logic [2:0]    LAST_BYTE = 3'(NB - 1);
  localparam logic [GW-1:0] LAST_GAP  = GW'(GAP_HALF - 1);
  localparam logic [4:0]    LAST_EDGE = 5'(EDGES_PER_BYTE - 1);
  localparam logic [4:0]    LAST_MOVE = 5'(EDGES_PER_BYTE - 2);

  if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
    $error("spi_frame_writer: DATA_W must be 1..32");
  end
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("spi_frame_writer: CLK_DIV must be at least 2");
  end
  if (GAP_HALF < 1) begin : g_bad_gap
    $error("spi_frame_writer: GAP_HALF must be at least 1");
  end

  // Returns {next bit on the wire, remaining shift register}.
`ifdef SPI_LSB_FIRST_EN
  function automatic logic [SW:0] pop(input logic [SW-1:0] v);
    return {v[0], v >> 1};
  endfunction
`else
  function automatic logic [SW:0] pop(input logic [SW-1:0] v);
    return {v[SW-1], v << 1};
  endfunction
`endif

  state_e        state_q, state_d;
  logic [SW-1:0] sr_q, sr_d;
  logic [4:0]    edge_q, edge_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [2:0]    byte_q, byte_d;
  logic          scl_q, scl_d;
  logic          ss_q, ss_d;
  logic          mosi_q, mosi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tick, clr, take;
  logic [4:0]    edge_n;
  logic [SW-1:0] load_v;
  logic [SW:0]   pop_cur, pop_load;

  assign load_v   = SW'(sample);
  assign pop_cur  = pop(sr_q);
  assign pop_load = pop(load_v);
  assign edge_n   = edge_q + 5'd1;

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (clr),
    .tick_o (tick)
  );

  // Frame sequencing: next state, SCL edges and MOSI bit stepping.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    edge_d  = edge_q;
    gap_d   = gap_q;
    byte_d  = byte_q;
    scl_d   = scl_q;
    ss_d    = ss_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        // done_q blocks a start seen in the cycle the previous frame ends.
        if (start && !done_q) begin
          clr     = 1'b1;
          ss_d    = 1'b0;
          busy_d  = 1'b1;
          byte_d  = 3'd0;
          edge_d  = 5'd0;
          state_d = SETUP;
          if (!CPHA) begin
            mosi_d = pop_load[SW];
            sr_d   = pop_load[SW-1:0];
          end else begin
            mosi_d = 1'b0;
            sr_d   = load_v;
          end
        end
      end
      SETUP, SHIFT: begin
        if (tick) begin
          edge_d = edge_n;
          scl_d  = ~scl_q;
          take   = CPHA ? edge_n[0] : (!edge_n[0] && (edge_n <= LAST_MOVE));
          if (state_q == SETUP) begin
            state_d = SHIFT;
          end else if (edge_q == LAST_EDGE) begin
            state_d = END;
          end
        end
      end
      END: begin
        if (tick) begin
          ss_d   = 1'b1;
          mosi_d = 1'b0;
          edge_d = 5'd0;
          if (byte_q < LAST_BYTE) begin
            byte_d  = byte_q + 3'd1;
            gap_d   = '0;
            state_d = GAP;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_q == LAST_GAP) begin
            ss_d    = 1'b0;
            take    = !CPHA;
            state_d = SETUP;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      mosi_d = pop_cur[SW];
      sr_d   = pop_cur[SW-1:0];
    end
  end

  // State and output registers; reset abandons any frame without a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      edge_q  <= 5'd0;
      gap_q   <= '0;
      byte_q  <= 3'd0;
      scl_q   <= CPOL;
      ss_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      edge_q  <= edge_d;
      gap_q   <= gap_d;
      byte_q  <= byte_d;
      scl_q   <= scl_d;
      ss_q    <= ss_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign SCL      = scl_q;
  assign SS       = ss_q;
  assign MOSI     = mosi_q;
  assign byte_idx = byte_q;

endmodule

// File: tb/tb_spi_frame_writer.sv
// tb/tb_spi_frame_writer.sv - directed bench for spi_frame_writer
module tb_spi_frame_writer;

  typedef logic [7:0] bq_t[$];

`ifdef SPI_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] sample_a, sample_b;
  logic [15:0] sample_c;
  logic        busy_a, done_a, SCL_a, SS_a, MOSI_a;
  logic        busy_b, done_b, SCL_b, SS_b, MOSI_b;
  logic        busy_c, done_c, SCL_c, SS_c, MOSI_c;
  logic [2:0]  bidx_a, bidx_b, bidx_c;

  int checks = 0;
  int errors = 0;

  bq_t  rx_a, rx_b, rx_c;
  logic prev_a, prev_b, prev_c;
  logic [7:0] acc_a, acc_b, acc_c;
  int   cnt_a = 0, cnt_b = 0, cnt_c = 0;

  always #5 clk = ~clk;

  spi_frame_writer #(.DATA_W(12), .CLK_DIV(4), .CPOL(1'b0), .CPHA(1'b1), .GAP_HALF(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .sample(sample_a), .busy(busy_a), .done(done_a),
    .SCL(SCL_a), .SS(SS_a), .MOSI(MOSI_a), .byte_idx(bidx_a));

  spi_frame_writer #(.DATA_W(12), .CLK_DIV(4), .CPOL(1'b1), .CPHA(1'b0), .GAP_HALF(1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .sample(sample_b), .busy(busy_b), .done(done_b),
    .SCL(SCL_b), .SS(SS_b), .MOSI(MOSI_b), .byte_idx(bidx_b));

  spi_frame_writer #(.DATA_W(16), .CLK_DIV(4), .CPOL(1'b0), .CPHA(1'b1), .GAP_HALF(1)) dut_c (
    .clk(clk), .rst(rst), .start(start), .sample(sample_c), .busy(busy_c), .done(done_c),
    .SCL(SCL_c), .SS(SS_c), .MOSI(MOSI_c), .byte_idx(bidx_c));

  // Child models: every DUT here samples MOSI on falling SCL while SS is low.
  always @(negedge clk) begin
    if (SS_a) cnt_a = 0;
    else if (prev_a && !SCL_a) begin
      acc_a = {acc_a[6:0], MOSI_a};
      cnt_a++;
      if (cnt_a == 8) begin rx_a.push_back(acc_a); cnt_a = 0; end
    end
    prev_a = SCL_a;
  end

  always @(negedge clk) begin
    if (SS_b) cnt_b = 0;
    else if (prev_b && !SCL_b) begin
      acc_b = {acc_b[6:0], MOSI_b};
      cnt_b++;
      if (cnt_b == 8) begin rx_b.push_back(acc_b); cnt_b = 0; end
    end
    prev_b = SCL_b;
  end

  always @(negedge clk) begin
    if (SS_c) cnt_c = 0;
    else if (prev_c && !SCL_c) begin
      acc_c = {acc_c[6:0], MOSI_c};
      cnt_c++;
      if (cnt_c == 8) begin rx_c.push_back(acc_c); cnt_c = 0; end
    end
    prev_c = SCL_c;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input bq_t q, input int base,
                             input logic [7:0] e0, input logic [7:0] e1);
    logic [7:0] g0, g1;
    g0 = (q.size() > base)     ? q[base]     : 8'hxx;
    g1 = (q.size() > base + 1) ? q[base + 1] : 8'hxx;
    check({tag, "_b0"}, {24'd0, g0}, {24'd0, e0});
    check({tag, "_b1"}, {24'd0, g1}, {24'd0, e1});
  endtask

  task automatic clear_rx();
    rx_a.delete(); rx_b.delete(); rx_c.delete();
  endtask

  // One-cycle start pulse, then measure dut_a until its done pulse (cycle 0 follows acceptance).
  task automatic run_frame(output int done_cyc, output int busy_cyc, output int ss_hi);
    done_cyc = -1; busy_cyc = 0; ss_hi = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 400 && done_cyc < 0; k++) begin
      if (k > 0) @(negedge clk);
      if (busy_a) busy_cyc++;
      if (busy_a && SS_a) ss_hi++;
      if (done_a) done_cyc = k;
    end
  endtask

  initial begin
    int d, bc, sh, n_done, bad_ss, bad_scl, bad_mosi, bad_busy, d1, d2, b141, b142;

    rst = 1'b0; start = 1'b0;
    sample_a = '0; sample_b = '0; sample_c = '0;
    repeat (3) @(negedge clk);
    check("rst_ss", SS_a, 1'b1);
    check("rst_scl_b", SCL_b, 1'b1);
    rst = 1'b1;

    // Idle after reset release.
    n_done = 0; bad_ss = 0; bad_scl = 0; bad_mosi = 0; bad_busy = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (SS_a !== 1'b1 || SS_b !== 1'b1) bad_ss++;
      if (SCL_a !== 1'b0 || SCL_b !== 1'b1) bad_scl++;
      if (MOSI_a !== 1'b0 || MOSI_b !== 1'b0) bad_mosi++;
      if (busy_a !== 1'b0 || busy_c !== 1'b0) bad_busy++;
      if (done_a || done_b || done_c) n_done++;
    end
    check("idle_ss", bad_ss, 0);
    check("idle_scl", bad_scl, 0);
    check("idle_mosi", bad_mosi, 0);
    check("idle_busy", bad_busy, 0);
    check("idle_done", n_done, 0);

    // Frame 1: timing plus content in both modes.
    clear_rx();
    sample_a = 12'hA5C; sample_b = 12'h3C1; sample_c = 16'h8001;
    run_frame(d, bc, sh);
    check("f1_done_cyc", d, 140);
    check("f1_busy_cyc", bc, 140);
    check("f1_gap_cyc", sh, 4);
    check("f1_busy_at_done", busy_a, 1'b0);
    check("f1_done_b", done_b, 1'b1);
    check("f1_done_c", done_c, 1'b1);
    check("f1_ss_end", SS_a, 1'b1);
    @(negedge clk);
    check("f1_done_pulse", done_a, 1'b0);
    check("f1_rx_a_n", rx_a.size(), 2);
    check_bytes("f1_a", rx_a, 0, LSB ? 8'h3A : 8'h0A, LSB ? 8'h50 : 8'h5C);
    check_bytes("f1_b", rx_b, 0, LSB ? 8'h83 : 8'h03, LSB ? 8'hC0 : 8'hC1);
    check_bytes("f1_c", rx_c, 0, 8'h80, 8'h01);

    // Frame 2: different patterns.
    clear_rx();
    sample_a = 12'h801; sample_b = 12'h0FF; sample_c = 16'h1234;
    run_frame(d, bc, sh);
    check("f2_done_cyc", d, 140);
    check_bytes("f2_a", rx_a, 0, LSB ? 8'h80 : 8'h08, LSB ? 8'h10 : 8'h01);
    check_bytes("f2_b", rx_b, 0, LSB ? 8'hFF : 8'h00, LSB ? 8'h00 : 8'hFF);
    check_bytes("f2_c", rx_c, 0, LSB ? 8'h2C : 8'h12, LSB ? 8'h48 : 8'h34);
    repeat (3) @(negedge clk);

    // start held high, sample changing every cycle.
    clear_rx();
    n_done = 0; d1 = -1; d2 = -1; b141 = -1; b142 = -1;
    @(negedge clk); start = 1'b1; sample_a = 12'h100;
    for (int k = 0; k <= 320; k++) begin
      @(negedge clk);
      sample_a = 12'h100 + 12'(k + 1);
      if (k == 283) start = 1'b0;
      if (k == 141) b141 = int'(busy_a);
      if (k == 142) b142 = int'(busy_a);
      if (done_a) begin
        n_done++;
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
    end
    check("hold_d1", d1, 140);
    check("hold_d2", d2, 282);
    check("hold_ndone", n_done, 2);
    check("hold_busy141", b141, 0);
    check("hold_busy142", b142, 1);
    check("hold_busy_end", busy_a, 1'b0);
    check("hold_rx_n", rx_a.size(), 4);
    check_bytes("hold_f1", rx_a, 0, LSB ? 8'h00 : 8'h01, LSB ? 8'h80 : 8'h00);
    check_bytes("hold_f2", rx_a, 2, LSB ? 8'h71 : 8'h01, LSB ? 8'h80 : 8'h8E);

    // Reset at cycle 60 of a frame.
    clear_rx();
    sample_a = 12'h3C5;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (60) @(negedge clk);
    check("pre_rst_ss", SS_a, 1'b0);
    check("pre_rst_scl", SCL_a, 1'b1);
    check("pre_rst_mosi", MOSI_a, 1'b1);
    check("pre_rst_scl_b", SCL_b, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_rst_ss", SS_a, 1'b1);
    check("mid_rst_scl", SCL_a, 1'b0);
    check("mid_rst_mosi", MOSI_a, 1'b0);
    check("mid_rst_busy", busy_a, 1'b0);
    check("mid_rst_scl_b", SCL_b, 1'b1);
    n_done = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done_a || done_b || done_c || busy_a) n_done++;
    end
    check("post_rst_quiet", n_done, 0);
    clear_rx();
    run_frame(d, bc, sh);
    check("post_rst_done_cyc", d, 140);
    check("post_rst_busy_cyc", bc, 140);
    check_bytes("post_rst_a", rx_a, 0, LSB ? 8'hA3 : 8'h03, LSB ? 8'hC0 : 8'hC5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
